// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial sequencer driving a 1-bit ALU slice LSB-first
module serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       alu_ctrl_i,
    output logic             slice_src1_o,
    output logic             slice_src2_o,
    output logic             slice_less_o,
    output logic             slice_A_invert_o,
    output logic             slice_B_invert_o,
    output logic             slice_cin_o,
    output logic [1:0]       slice_operation_o,
    input  logic             slice_result_i,
    input  logic             slice_cout_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    typedef enum logic [1:0] {IDLE, RUN, LESS_PASS, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_sh;
    logic [3:0]       op_r;
    logic             carry_r;
    logic             set_r;
    logic             cout_msb_r;

    logic [1:0]       dec_op;
    logic             dec_ainv;
    logic             dec_binv;
    logic             dec_sub;
    logic             is_slt;
    logic [WIDTH-1:0] res_next;
    logic             ovf_msb;

    function automatic logic code_legal(input logic [3:0] c);
        case (c)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        dec_op   = 2'd0;
        dec_ainv = 1'b0;
        dec_binv = 1'b0;
        dec_sub  = 1'b0;
        is_slt   = 1'b0;
        case (op_r)
            OP_OR:   dec_op = 2'd1;
            OP_ADD:  dec_op = 2'd2;
            OP_SUB: begin
                dec_op   = 2'd2;
                dec_binv = 1'b1;
                dec_sub  = 1'b1;
            end
            OP_SLT: begin
                dec_op   = 2'd2;
                dec_binv = 1'b1;
                dec_sub  = 1'b1;
                is_slt   = 1'b1;
            end
            OP_NOR: begin
                dec_ainv = 1'b1;
                dec_binv = 1'b1;
            end
            OP_NAND: begin
                dec_op   = 2'd1;
                dec_ainv = 1'b1;
                dec_binv = 1'b1;
            end
            default: ;
        endcase
    end

    // Slice inputs follow the bit counter directly so the slice sees bit k during cycle k.
    always_comb begin
        slice_src1_o      = 1'b0;
        slice_src2_o      = 1'b0;
        slice_less_o      = 1'b0;
        slice_A_invert_o  = 1'b0;
        slice_B_invert_o  = 1'b0;
        slice_cin_o       = 1'b0;
        slice_operation_o = 2'd0;
        case (state)
            RUN: begin
                slice_src1_o      = a_r[cnt];
                slice_src2_o      = b_r[cnt];
                slice_A_invert_o  = dec_ainv;
                slice_B_invert_o  = dec_binv;
                slice_cin_o       = (cnt == '0) ? dec_sub : carry_r;
                slice_operation_o = dec_op;
            end
            LESS_PASS: begin
                slice_src1_o      = a_r[cnt];
                slice_src2_o      = b_r[cnt];
                slice_less_o      = (cnt == '0) ? set_r : 1'b0;
                slice_operation_o = 2'd3;
            end
            default: ;
        endcase
    end

    assign res_next = {slice_result_i, res_sh[WIDTH-1:1]};
    assign ovf_msb  = slice_cin_o ^ slice_cout_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            a_r        <= '0;
            b_r        <= '0;
            res_sh     <= '0;
            op_r       <= '0;
            carry_r    <= 1'b0;
            set_r      <= 1'b0;
            cout_msb_r <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        if (code_legal(alu_ctrl_i)) begin
                            a_r     <= src1_i;
                            b_r     <= src2_i;
                            op_r    <= alu_ctrl_i;
                            cnt     <= '0;
                            carry_r <= 1'b0;
                            busy_o  <= 1'b1;
                            state   <= RUN;
                        end else begin
                            result_o   <= '0;
                            zero_o     <= 1'b1;
                            cout_o     <= 1'b0;
                            overflow_o <= 1'b0;
                            done_o     <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                RUN: begin
                    res_sh  <= res_next;
                    carry_r <= slice_cout_i;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (is_slt) begin
                            // The sign of the true difference is the MSB sum corrected by overflow.
                            set_r      <= slice_result_i ^ ovf_msb;
                            cout_msb_r <= slice_cout_i;
                            state      <= LESS_PASS;
                        end else begin
                            result_o   <= res_next;
                            zero_o     <= (res_next == '0);
                            cout_o     <= (dec_op == 2'd2) ? slice_cout_i : 1'b0;
                            overflow_o <= (dec_op == 2'd2) ? ovf_msb : 1'b0;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                LESS_PASS: begin
                    res_sh <= res_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        result_o   <= res_next;
                        zero_o     <= (res_next == '0);
                        cout_o     <= cout_msb_r;
                        overflow_o <= 1'b0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb/tb_serial_alu_ctrl.sv - directed and random checks of serial_alu_ctrl against an arithmetic model
module tb_serial_alu_ctrl;

    localparam int W = 8;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_NAND = 4'b1101;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] src1_i = '0;
    logic [W-1:0] src2_i = '0;
    logic [3:0]   alu_ctrl_i = '0;
    logic         slice_src1_o, slice_src2_o, slice_less_o;
    logic         slice_A_invert_o, slice_B_invert_o, slice_cin_o;
    logic [1:0]   slice_operation_o;
    logic         slice_result_i, slice_cout_i;
    logic         busy_o, done_o, zero_o, cout_o, overflow_o;
    logic [W-1:0] result_o;

    int errors = 0;
    int checks = 0;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .src1_i(src1_i), .src2_i(src2_i), .alu_ctrl_i(alu_ctrl_i),
        .slice_src1_o(slice_src1_o), .slice_src2_o(slice_src2_o),
        .slice_less_o(slice_less_o), .slice_A_invert_o(slice_A_invert_o),
        .slice_B_invert_o(slice_B_invert_o), .slice_cin_o(slice_cin_o),
        .slice_operation_o(slice_operation_o),
        .slice_result_i(slice_result_i), .slice_cout_i(slice_cout_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .zero_o(zero_o), .cout_o(cout_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Behavioural 1-bit ALU slice
    logic sa, sb;
    assign sa = slice_src1_o ^ slice_A_invert_o;
    assign sb = slice_src2_o ^ slice_B_invert_o;
    assign slice_result_i = (slice_operation_o == 2'd0) ? (sa & sb) :
                            (slice_operation_o == 2'd1) ? (sa | sb) :
                            (slice_operation_o == 2'd2) ? (sa ^ sb ^ slice_cin_o) : slice_less_o;
    assign slice_cout_i = (sa & sb) | (sa & slice_cin_o) | (sb & slice_cin_o);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] r, output logic c, output logic v,
                             output int lat, output int busy, output logic cin0);
        int sa_i, sb_i, s;
        sa_i = $signed(a);
        sb_i = $signed(b);
        c = 1'b0; v = 1'b0; r = '0; cin0 = 1'b0;
        lat = W + 1; busy = W;
        case (op)
            C_AND:  r = a & b;
            C_OR:   r = a | b;
            C_NOR:  r = ~(a | b);
            C_NAND: r = ~(a & b);
            C_ADD: begin
                r = a + b;
                c = (int'(a) + int'(b)) >= (1 << W);
                s = sa_i + sb_i;
                v = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
            end
            C_SUB: begin
                r = a - b;
                c = (a >= b);
                s = sa_i - sb_i;
                v = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
                cin0 = 1'b1;
            end
            C_SLT: begin
                r = (sa_i < sb_i) ? 1 : 0;
                c = (a >= b);
                cin0 = 1'b1;
                lat = 2 * W + 1;
                busy = 2 * W;
            end
            default: begin
                lat = 1;
                busy = 0;
            end
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit hold);
        logic [W-1:0] er, got_r;
        logic ec, ev, ecin0, got_z, got_c, got_v, cin0, less0;
        logic [1:0] op0;
        int elat, ebusy, lat, busy, dones;
        ref_model(op, a, b, er, ec, ev, elat, ebusy, ecin0);
        lat = 0; busy = 0; dones = 0; cin0 = 1'b0; less0 = 1'b0; op0 = 2'd0;
        got_r = '0; got_z = 1'b0; got_c = 1'b0; got_v = 1'b0;
        @(negedge clk);
        start_i = 1'b1; src1_i = a; src2_i = b; alu_ctrl_i = op;
        for (int i = 0; i < 2 * W + 6; i++) begin
            @(posedge clk); #1;
            if (!hold) start_i = 1'b0;
            if (i == 0) cin0 = slice_cin_o;
            if (i == W) begin
                op0 = slice_operation_o;
                less0 = slice_less_o;
            end
            if (busy_o) busy++;
            if (done_o) begin
                dones++;
                if (dones == 1) begin
                    lat = i + 1;
                    got_r = result_o; got_z = zero_o; got_c = cout_o; got_v = overflow_o;
                end
                start_i = 1'b0;
            end
        end
        check({tag, " result"}, got_r, er);
        check({tag, " zero"}, got_z, (er == '0));
        check({tag, " cout"}, got_c, ec);
        check({tag, " overflow"}, got_v, ev);
        check({tag, " latency"}, lat, elat);
        check({tag, " busy cycles"}, busy, ebusy);
        check({tag, " done pulses"}, dones, 1);
        check({tag, " cin k0"}, cin0, ecin0);
        if (op == C_SLT) begin
            check({tag, " less op"}, op0, 2'd3);
            check({tag, " less bit"}, less0, er[0]);
        end
    endtask

    initial begin
        logic [3:0] codes [8];
        logic [3:0] op;
        logic [W-1:0] ra, rb;
        codes = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_NOR, C_NAND, 4'b1111};

        repeat (2) @(posedge clk);
        #1;
        check("reset outputs",
              {busy_o, done_o, zero_o, cout_o, overflow_o, slice_src1_o, slice_src2_o,
               slice_less_o, slice_A_invert_o, slice_B_invert_o, slice_cin_o,
               slice_operation_o, result_o}, '0);
        @(negedge clk);
        rst_i = 1'b1;

        run_op("add ovf", C_ADD, 8'h7F, 8'h01, 1'b0);
        run_op("sub eq", C_SUB, 8'h05, 8'h05, 1'b0);
        run_op("slt neg", C_SLT, 8'h80, 8'h01, 1'b0);
        run_op("slt pos", C_SLT, 8'h01, 8'h80, 1'b0);
        run_op("nor", C_NOR, 8'hF0, 8'h0C, 1'b0);
        run_op("nand", C_NAND, 8'hFF, 8'h0F, 1'b0);
        run_op("and", C_AND, 8'hA5, 8'h3C, 1'b0);
        run_op("or", C_OR, 8'hA5, 8'h3C, 1'b0);
        run_op("add held", C_ADD, 8'h33, 8'h44, 1'b1);
        run_op("illegal", 4'b1111, 8'h12, 8'h34, 1'b0);

        // Abort an ADD at bit 3 with reset.
        run_op("pre reset", C_OR, 8'h5A, 8'h00, 1'b0);
        @(negedge clk);
        start_i = 1'b1; src1_i = 8'h11; src2_i = 8'h22; alu_ctrl_i = C_ADD;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check("abort outputs",
              {busy_o, done_o, zero_o, cout_o, overflow_o, slice_src1_o, slice_src2_o,
               slice_less_o, slice_A_invert_o, slice_B_invert_o, slice_cin_o,
               slice_operation_o, result_o}, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort no done", done_o, 1'b0);
        end
        @(negedge clk);
        rst_i = 1'b1;
        run_op("add after reset", C_ADD, 8'h10, 8'h20, 1'b0);

        for (int n = 0; n < 14; n++) begin
            op = codes[$urandom_range(0, 7)];
            ra = W'($urandom);
            rb = W'($urandom);
            run_op("random", op, ra, rb, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
- Bit-serial sequencer that sits directly upstream of the 1-bit ALU slice (alu_top) and drives it.
- Accepts a WIDTH-bit operation and feeds operand bits LSB-first, one per cycle, into the slice.
- Holds the ripple carry in a register between bits and assembles the WIDTH-bit result, zero, carry-out and overflow.
- SLT uses a second pass through the slice's less path, so the whole slice (including less and operation=3) is exercised in-system.

Parameters:
- WIDTH, default 32: operand/result width in bits; legal range 2..64.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  request; sampled only in IDLE
- src1_i  in  WIDTH  operand A; latched when start_i is accepted
- src2_i  in  WIDTH  operand B; latched when start_i is accepted
- alu_ctrl_i  in  4  op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND; latched with the operands
- slice_src1_o  out  1  operand A bit to the slice
- slice_src2_o  out  1  operand B bit to the slice
- slice_less_o  out  1  less input to the slice
- slice_A_invert_o  out  1  A_invert to the slice
- slice_B_invert_o  out  1  B_invert to the slice
- slice_cin_o  out  1  carry-in to the slice
- slice_operation_o  out  2  slice op: 0 AND, 1 OR, 2 ADD, 3 LESS
- slice_result_i  in  1  slice result (combinational from slice_* outputs)
- slice_cout_i  in  1  slice carry-out (combinational)
- busy_o  out  1  high while a pass is in progress
- done_o  out  1  one-cycle completion pulse
- result_o  out  WIDTH  final result; holds until the next accepted start
- zero_o  out  1  result_o == 0
- cout_o  out  1  MSB carry-out (ADD/SUB/SLT), else 0
- overflow_o  out  1  signed overflow (ADD/SUB only), else 0

Behaviour:
- Reset (async, rst_i=0): state IDLE. All outputs 0, including result_o, zero_o and all slice_* signals. Bit counter, carry and shift registers are cleared. Reset mid-operation aborts immediately with no done pulse.
- States and transitions:
  - IDLE -> RUN on start_i=1 with a legal code.
  - IDLE -> DONE on start_i=1 with an illegal code: result_o=0, zero_o=1, cout_o=0, overflow_o=0.
  - RUN -> LESS_PASS after bit WIDTH-1 when the code is SLT.
  - RUN -> DONE after bit WIDTH-1 for all other codes.
  - LESS_PASS -> DONE after bit WIDTH-1.
  - DONE -> IDLE unconditionally.
- start_i is ignored in RUN, LESS_PASS and DONE.
- RUN: cycle k (k = 0..WIDTH-1) drives slice_src1_o=A[k] and slice_src2_o=B[k].
- Slice control per code:

  | Code | operation | A_invert | B_invert | less |
  |------|-----------|----------|----------|------|
  | AND  | 0         | 0        | 0        | 0    |
  | OR   | 1         | 0        | 0        | 0    |
  | ADD  | 2         | 0        | 0        | 0    |
  | SUB, SLT | 2     | 0        | 1        | 0    |
  | NOR  | 0         | 1        | 1        | 0    |
  | NAND | 1         | 1        | 1        | 0    |

- Carry: slice_cin_o at k=0 is 1 for SUB/SLT and 0 otherwise. For k>0 it is the carry register, which captures slice_cout_i at each RUN edge.
- Result shift: at each RUN edge the result register shifts right with slice_result_i inserted at the MSB. After WIDTH edges the bits are aligned.
- MSB capture (k=WIDTH-1): record cin_msb = slice_cin_o and cout_msb = slice_cout_i. Then:
  - overflow = cin_msb ^ cout_msb
  - set = sum_msb ^ overflow
- LESS_PASS (SLT only):
  - Drives operation=3, A_invert=0, B_invert=0, cin=0, src1/src2 = operand bits, for WIDTH cycles.
  - slice_less_o = set at k=0, else 0.
  - Result shifts in the same way, so the final result is {WIDTH-1 zeros, set}.
  - cout_o = cout_msb from RUN; overflow_o = 0.
- Outputs:
  - result_o, zero_o, cout_o and overflow_o update on the edge entering DONE.
  - done_o is high for exactly the DONE cycle.
  - busy_o is high in RUN and LESS_PASS only.
- Latency, counted from the edge sampling start_i to done_o high:
  - WIDTH+1 edges for AND/OR/ADD/SUB/NOR/NAND.
  - 2*WIDTH+1 edges for SLT.
  - 1 edge for an illegal code.
- All slice_* outputs are 0 in IDLE and DONE.
- Arithmetic is modulo 2^WIDTH; operands are two's complement for overflow and SLT.

Test Plan (WIDTH=8, behavioural slice model in bench):
- ADD 0x7F+0x01 -> done_o on edge 9; result 0x80, cout 0, overflow 1, zero 0.
- SUB 0x05-0x05 -> result 0x00, zero 1, cout 1, overflow 0; slice_cin_o=1 at k=0.
- SLT 0x80 vs 0x01 -> result 0x01 at edge 17, busy_o high for 16 cycles. SLT 0x01 vs 0x80 -> result 0x00.
- NOR 0xF0,0x0C -> 0x03; NAND 0xFF,0x0F -> 0xF0; AND/OR 0xA5,0x3C -> 0x24 / 0xBD; cout and overflow 0.
- start_i held high through an ADD -> exactly one operation and one done pulse. Illegal code 1111 -> done_o at edge 1, result 0, zero 1.
- rst_i low at RUN bit 3 -> all outputs 0 immediately, no done_o. A fresh ADD 0x10+0x20 after release -> 0x30.
